// File: rtl/ram_mp_rw.sv
// ---------------------------------------------------------------------------
// ram_mp_rw
// Multi-port register-file RAM: NUM_WR write ports and NUM_RD read ports,
// one valid bit per entry, synchronous flash-clear of the valid bits and
// one-cycle registered reads.
//
// Configuration macro:
//   RAM_MP_RW_BYPASS_EN - when defined, a read that addresses an entry being
//                         written in the same cycle returns the new data
//                         (highest-index writer) with rd_hit_o=1. When
//                         undefined, such a read returns the pre-write
//                         contents and pre-write valid bit.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous, active-high reset
//   wr_en_i        per-port write enable             [NUM_WR]
//   wr_addr_i      packed write addresses            [NUM_WR*ADDR_WIDTH]
//   wr_data_i      packed write data                 [NUM_WR*DATA_WIDTH]
//   rd_en_i        per-port read enable              [NUM_RD]
//   rd_addr_i      packed read addresses             [NUM_RD*ADDR_WIDTH]
//   clear_i        flash-clear of all valid bits
//   rd_data_o      registered read data              [NUM_RD*DATA_WIDTH]
//   rd_valid_o     registered: read performed last cycle
//   rd_hit_o       registered: entry read was valid
//   wr_conflict_o  registered: two or more enabled in-range writes collided
// ---------------------------------------------------------------------------
module ram_mp_rw #(
    parameter int DATA_WIDTH = 8,
    parameter int ENTRIES    = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WR     = 3,
    parameter int NUM_RD     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_RD-1:0]            rd_en_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                         clear_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_valid_o,
    output logic [NUM_RD-1:0]            rd_hit_o,
    output logic                         wr_conflict_o
);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
    logic [ENTRIES-1:0]    valid_q;

    // Per-entry view of this cycle's writes: which entries are written and
    // with what data once same-address collisions have been resolved.
    logic [ENTRIES-1:0]    ent_we;
    logic [DATA_WIDTH-1:0] ent_wdata [ENTRIES];

    logic [ADDR_WIDTH-1:0] wr_addr [NUM_WR];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD];
    logic                  wr_ok   [NUM_WR];
    logic                  rd_ok   [NUM_RD];
    logic                  conflict_d;

    // Addresses can encode values beyond the last entry when ENTRIES is not
    // a power of two; those are treated as out of range.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(ENTRIES);
    endfunction

    // Unpack the address buses and flag which ports target a real entry.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr[p] = wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wr_ok[p]   = wr_en_i[p] && addr_in_range(wr_addr[p]);
        end
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_ok[k]   = addr_in_range(rd_addr[k]);
        end
    end

    // Write decode. Ports are walked in ascending order so a later (higher
    // index) port overwrites an earlier one at the same entry, which gives
    // the highest-index-wins rule for free.
    always_comb begin
        ent_we = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            ent_wdata[e] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) begin
                ent_we[wr_addr[p]]    = 1'b1;
                ent_wdata[wr_addr[p]] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Collision detection: any pair of enabled, in-range write ports aimed
    // at the same entry. Out-of-range writes are dropped before this point
    // so they never count as a collision.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_ok[i] && wr_ok[j] && (wr_addr[i] == wr_addr[j])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Storage and valid bits. A clear wipes every valid bit, but entries
    // written in the same cycle are set again, so a write issued alongside
    // a clear survives it. Clearing never touches the stored data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                mem_q[e] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (ent_we[e]) begin
                    mem_q[e] <= ent_wdata[e];
                end
            end
            if (clear_i) begin
                valid_q <= ent_we;
            end else begin
                valid_q <= valid_q | ent_we;
            end
        end
    end

    // Registered read ports. Idle ports hold their last data and hit flag
    // and only drop rd_valid_o. Reads sample the pre-edge valid bits, so a
    // read alongside a clear still reports the hit status from before it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_o  <= '0;
            rd_valid_o <= '0;
            rd_hit_o   <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_valid_o[k] <= rd_en_i[k];
                if (rd_en_i[k]) begin
                    if (!rd_ok[k]) begin
                        rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        rd_hit_o[k]                           <= 1'b0;
                    end
`ifdef RAM_MP_RW_BYPASS_EN
                    else if (ent_we[rd_addr[k]]) begin
                        rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] <= ent_wdata[rd_addr[k]];
                        rd_hit_o[k]                           <= 1'b1;
                    end
`endif
                    else begin
                        rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] <= mem_q[rd_addr[k]];
                        rd_hit_o[k]                           <= valid_q[rd_addr[k]];
                    end
                end
            end
        end
    end

    // Collision flag is reported one cycle after the colliding writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict_o <= 1'b0;
        end else begin
            wr_conflict_o <= conflict_d;
        end
    end

endmodule

// File: tb/tb_ram_mp_rw.sv
// ---------------------------------------------------------------------------
// tb_ram_mp_rw
// Self-checking bench for ram_mp_rw, built with ENTRIES=24 so that part of
// the 5-bit address space is out of range. Directed scenarios are followed
// by randomized traffic; every cycle the DUT outputs are compared against a
// behavioural model of the RAM kept in plain arrays. Define
// RAM_MP_RW_BYPASS_EN for both DUT and bench to exercise the bypass build.
// ---------------------------------------------------------------------------
module tb_ram_mp_rw;

    localparam int DW = 8;
    localparam int EN = 24;
    localparam int AW = 5;
    localparam int NW = 3;
    localparam int NR = 3;

    logic              clk;
    logic              rst;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic              clear;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     rd_hit;
    logic              wr_conflict;

    int checks = 0;
    int errors = 0;

    // Reference model state: memory contents, valid bits and the output
    // values the DUT should be showing right now.
    logic [DW-1:0] m_mem   [EN];
    logic          m_valid [EN];
    logic [DW-1:0] e_data  [NR];
    logic          e_hit   [NR];
    logic          e_valid [NR];
    logic          e_conflict;

    ram_mp_rw #(
        .DATA_WIDTH (DW),
        .ENTRIES    (EN),
        .ADDR_WIDTH (AW),
        .NUM_WR     (NW),
        .NUM_RD     (NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .clear_i       (clear),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .rd_hit_o      (rd_hit),
        .wr_conflict_o (wr_conflict)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int e = 0; e < EN; e++) begin
            m_mem[e]   = '0;
            m_valid[e] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            e_data[k]  = '0;
            e_hit[k]   = 1'b0;
            e_valid[k] = 1'b0;
        end
        e_conflict = 1'b0;
    endtask

    task automatic setIdle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        clear   = 1'b0;
    endtask

    task automatic setWrite(input int p, input int a, input int d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = DW'(d);
    endtask

    task automatic setRead(input int k, input int a);
        rd_en[k]            = 1'b1;
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic randomInputs();
        int narrow;
        narrow = int'($urandom_range(0, 1));
        wr_en  = NW'($urandom);
        rd_en  = NR'($urandom);
        for (int p = 0; p < NW; p++) begin
            wr_addr[p*AW +: AW] = AW'(narrow != 0 ? $urandom_range(0, 5) : $urandom_range(0, 31));
            wr_data[p*DW +: DW] = DW'($urandom);
        end
        for (int k = 0; k < NR; k++) begin
            rd_addr[k*AW +: AW] = AW'(narrow != 0 ? $urandom_range(0, 5) : $urandom_range(0, 31));
        end
        clear = ($urandom_range(0, 15) == 0);
    endtask

    // Advance the model by one clock edge using the inputs currently held.
    // Reads see the state from before the edge; writes then land in port
    // order so the last port to write an address owns it.
    task automatic modelEdge();
        int cnt [EN];
        int a;
        if (rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < NR; k++) begin
            e_valid[k] = rd_en[k];
            if (rd_en[k]) begin
                a = int'(rd_addr[k*AW +: AW]);
                if (a >= EN) begin
                    e_data[k] = '0;
                    e_hit[k]  = 1'b0;
                end else begin
                    e_data[k] = m_mem[a];
                    e_hit[k]  = m_valid[a];
`ifdef RAM_MP_RW_BYPASS_EN
                    for (int p = 0; p < NW; p++) begin
                        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
                            e_data[k] = wr_data[p*DW +: DW];
                            e_hit[k]  = 1'b1;
                        end
                    end
`endif
                end
            end
        end
        for (int e = 0; e < EN; e++) begin
            cnt[e] = 0;
        end
        for (int p = 0; p < NW; p++) begin
            a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && a < EN) begin
                cnt[a]++;
            end
        end
        e_conflict = 1'b0;
        for (int e = 0; e < EN; e++) begin
            if (cnt[e] >= 2) begin
                e_conflict = 1'b1;
            end
        end
        if (clear) begin
            for (int e = 0; e < EN; e++) begin
                m_valid[e] = 1'b0;
            end
        end
        for (int p = 0; p < NW; p++) begin
            a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && a < EN) begin
                m_mem[a]   = wr_data[p*DW +: DW];
                m_valid[a] = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        for (int k = 0; k < NR; k++) begin
            checkOutput($sformatf("rd_valid%0d", k), 32'(rd_valid[k]), 32'(e_valid[k]));
            checkOutput($sformatf("rd_hit%0d", k), 32'(rd_hit[k]), 32'(e_hit[k]));
            checkOutput($sformatf("rd_data%0d", k), 32'(rd_data[k*DW +: DW]), 32'(e_data[k]));
        end
        checkOutput("wr_conflict", 32'(wr_conflict), 32'(e_conflict));
    endtask

    // One clock edge: outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        modelEdge();
        compareAll();
    endtask

    // Assert reset between edges and confirm outputs drop without a clock,
    // hold it across two edges of random traffic, then release it.
    task automatic asyncResetCheck();
        #2 rst = 1'b1;
        #1;
        modelReset();
        compareAll();
        randomInputs();
        applyStimulus();
        randomInputs();
        applyStimulus();
        #3 rst = 1'b0;
    endtask

    initial begin
        setIdle();
        modelReset();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        #3 rst = 1'b0;

        // Fresh RAM: every port reads address 5 and sees nothing stored.
        setIdle();
        for (int k = 0; k < NR; k++) setRead(k, 5);
        applyStimulus();
        checkOutput("reset_read_data", 32'(rd_data), 32'(0));
        checkOutput("reset_read_hit", 32'(rd_hit), 32'(0));
        checkOutput("reset_read_valid", 32'(rd_valid), 32'(3'b111));

        // Single write then read-back on another port.
        setIdle();
        setWrite(0, 3, 8'hA5);
        applyStimulus();
        setIdle();
        setRead(2, 3);
        applyStimulus();
        checkOutput("wr3_rd_data", 32'(rd_data[2*DW +: DW]), 32'h0000_00A5);
        checkOutput("wr3_rd_hit", 32'(rd_hit[2]), 32'(1));

        // Three-way collision: conflict flagged, highest port wins.
        setIdle();
        setWrite(0, 7, 8'h11);
        setWrite(1, 7, 8'h22);
        setWrite(2, 7, 8'h33);
        applyStimulus();
        checkOutput("collide_flag", 32'(wr_conflict), 32'(1));
        setIdle();
        setRead(0, 7);
        applyStimulus();
        checkOutput("collide_data", 32'(rd_data[DW-1:0]), 32'h0000_0033);
        checkOutput("collide_flag_off", 32'(wr_conflict), 32'(0));

        // Read and write of the same entry in the same cycle.
        setIdle();
        setWrite(0, 9, 8'h5A);
        setRead(1, 9);
        applyStimulus();
`ifdef RAM_MP_RW_BYPASS_EN
        checkOutput("same_cycle_data", 32'(rd_data[DW +: DW]), 32'h0000_005A);
        checkOutput("same_cycle_hit", 32'(rd_hit[1]), 32'(1));
`else
        checkOutput("same_cycle_data", 32'(rd_data[DW +: DW]), 32'h0000_0000);
        checkOutput("same_cycle_hit", 32'(rd_hit[1]), 32'(0));
`endif

        // Clear together with a write: the written entry stays valid.
        setIdle();
        clear = 1'b1;
        setWrite(0, 1, 8'h44);
        applyStimulus();
        setIdle();
        setRead(0, 1);
        setRead(1, 3);
        applyStimulus();
        checkOutput("clear_wr_data", 32'(rd_data[DW-1:0]), 32'h0000_0044);
        checkOutput("clear_wr_hit", 32'(rd_hit[0]), 32'(1));
        checkOutput("clear_old_data", 32'(rd_data[DW +: DW]), 32'h0000_00A5);
        checkOutput("clear_old_hit", 32'(rd_hit[1]), 32'(0));

        // Out-of-range address: writes dropped, no conflict, read gives 0.
        setIdle();
        setWrite(0, 30, 8'h77);
        setWrite(1, 30, 8'h88);
        setRead(2, 30);
        applyStimulus();
        checkOutput("oor_conflict", 32'(wr_conflict), 32'(0));
        checkOutput("oor_data", 32'(rd_data[2*DW +: DW]), 32'(0));
        checkOutput("oor_hit", 32'(rd_hit[2]), 32'(0));
        checkOutput("oor_valid", 32'(rd_valid[2]), 32'(1));

        // Random traffic, then reset mid-stream, then more random traffic.
        for (int i = 0; i < 200; i++) begin
            randomInputs();
            applyStimulus();
        end
        asyncResetCheck();

        // Entries written before the reset must read back as empty.
        setIdle();
        setRead(0, 3);
        setRead(1, 7);
        setRead(2, 1);
        applyStimulus();
        checkOutput("post_rst_data", 32'(rd_data), 32'(0));
        checkOutput("post_rst_hit", 32'(rd_hit), 32'(0));

        for (int i = 0; i < 200; i++) begin
            randomInputs();
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
